exc_ctrl: RTL

//  Exception/redirect sequencer for the execute stage. Watches ALU overflow, external IRQ and ERET.

---
 rtl/exc_pkg.sv | 27 ++
 rtl/exc_ctrl_flush_timer.sv | 40 ++++
 rtl/exc_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the execute-stage exception sequencer.
//   state_t        : sequencer state encoding (IDLE / FLUSH)
//   CAUSE_*        : cause codes captured into the cause register
//   EXC_VECTOR_DEF : default handler entry PC
//   log2_ceil      : bit width needed to hold values 0..value-1
package exc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]  CAUSE_INT      = 4'd0;
  localparam logic [3:0]  CAUSE_OVF      = 4'd12;
  localparam logic [27:0] EXC_VECTOR_DEF = 28'h0000020;

  // Elaboration-time helper; result is at least 1 so a counter is never 0 bits wide.
  function automatic int log2_ceil(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/exc_ctrl_flush_timer.sv
// Flush window timer.
//   i_clk   : clock, rising edge
//   i_arst  : asynchronous reset, active-high
//   i_load  : restart the window (counter to 0)
//   i_count : advance one cycle of the window
//   o_first : counter is at 0 (first cycle of the window)
//   o_done  : counter is at the last cycle of the window
module flush_timer
  import exc_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = log2_ceil(FLUSH_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_load,
  input  logic i_count,
  output logic o_first,
  output logic o_done
);

  logic [CNT_W-1:0] cnt;

  assign o_first = (cnt == '0);
  assign o_done  = (cnt == CNT_W'(FLUSH_CYCLES - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= '0;
    end else if (i_count) begin
      // Self-clearing on the last cycle, so the counter never wraps.
      cnt <= o_done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/redirect sequencer for the execute stage.
// Detects ALU overflow traps, enabled external interrupts and ERET, kills the
// faulting execute instruction, maintains EPC/cause/IE, then flushes the front
// end for FLUSH_CYCLES cycles while issuing a single PC redirect.
//   i_clk, i_arst      : clock / async active-high reset
//   i_valid_ex, i_pc_ex: execute-stage instruction valid and PC
//   i_ovf_ex, i_ovf_trap_en : overflow flag and trap-on-overflow qualifier
//   i_irq              : level interrupt request (gated by IE)
//   i_eret_de          : ERET seen in decode
//   i_stall            : pipeline stalled, no event accepted
//   i_ie_we, i_ie_wdata: software IE write
//   o_ex_kill          : combinational squash of the execute instruction
//   o_de_flush         : front-end flush, held for the whole FLUSH state
//   o_redirect_en/_pc  : one-cycle redirect strobe and target (0 when idle)
//   o_epc, o_cause, o_ie : CP0 registers
//   o_busy             : sequencer is in FLUSH
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int                  PC_WIDTH     = 28,
  parameter int                  CAUSE_WIDTH  = 4,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = PC_WIDTH'(EXC_VECTOR_DEF),
  parameter int                  FLUSH_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_valid_ex,
  input  logic [PC_WIDTH-1:0]    i_pc_ex,
  input  logic                   i_ovf_ex,
  input  logic                   i_ovf_trap_en,
  input  logic                   i_irq,
  input  logic                   i_eret_de,
  input  logic                   i_stall,
  input  logic                   i_ie_we,
  input  logic                   i_ie_wdata,
  output logic                   o_ex_kill,
  output logic                   o_de_flush,
  output logic                   o_redirect_en,
  output logic [PC_WIDTH-1:0]    o_redirect_pc,
  output logic [PC_WIDTH-1:0]    o_epc,
  output logic [CAUSE_WIDTH-1:0] o_cause,
  output logic                   o_ie,
  output logic                   o_busy
);

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   epc, target;
  logic [CAUSE_WIDTH-1:0] cause;
  logic                  ie;
  logic                  accept, ev_ovf, ev_irq, take_exc, take_eret;
  logic                  tmr_first, tmr_done;

  // Reset is folded in so the kill strobe is also silent while held in reset.
  assign accept    = (state == ST_IDLE) & ~i_stall & ~i_arst;
  assign ev_ovf    = i_valid_ex & i_ovf_trap_en & i_ovf_ex;
  assign ev_irq    = i_valid_ex & i_irq & ie;
  assign take_exc  = accept & (ev_ovf | ev_irq);
  assign take_eret = accept & i_eret_de & ~(ev_ovf | ev_irq);

  flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .i_clk  (i_clk),
    .i_arst (i_arst),
    .i_load (take_exc | take_eret),
    .i_count(state == ST_FLUSH),
    .o_first(tmr_first),
    .o_done (tmr_done)
  );

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (take_exc || take_eret) state_nxt = ST_FLUSH;
      ST_FLUSH: if (tmr_done)              state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // CP0 registers. Entry clear / ERET set of IE take priority over a software
  // write; writes only land while idle.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      epc    <= '0;
      cause  <= '0;
      ie     <= 1'b0;
      target <= '0;
    end else if (take_exc) begin
      epc    <= i_pc_ex;
      cause  <= ev_ovf ? CAUSE_WIDTH'(CAUSE_OVF) : CAUSE_WIDTH'(CAUSE_INT);
      ie     <= 1'b0;
      target <= EXC_VECTOR;
    end else if (take_eret) begin
      ie     <= 1'b1;
      target <= epc;
    end else if (state == ST_IDLE && i_ie_we) begin
      ie     <= i_ie_wdata;
    end
  end

  assign o_ex_kill     = take_exc;
  assign o_de_flush    = (state == ST_FLUSH);
  assign o_busy        = (state == ST_FLUSH);
  assign o_redirect_en = (state == ST_FLUSH) & tmr_first;
  assign o_redirect_pc = o_redirect_en ? target : '0;
  assign o_epc         = epc;
  assign o_cause       = cause;
  assign o_ie          = ie;

endmodule
